// File: rtl/instr_loader_pkg.sv
// Shared types and default sizes for the instruction memory loader
// and the instruction block it feeds.
package instr_loader_pkg;

    localparam int IMEM_AWIDTH = 6;
    localparam int IMEM_RWIDTH = 32;

    typedef enum logic [1:0] {
        LDR_IDLE,
        LDR_LOAD,
        LDR_DONE
    } ldr_state_t;

endpackage

// File: rtl/ldr_addr_ctr.sv
// Loadable write-address counter; tc flags the last memory word
// so the loader can stop without wrapping.
module ldr_addr_ctr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

    assign tc = &q;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a valid/ready word stream into instruction memory from
// start_addr, holding the CPU fetch path until the session ends.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int AWIDTH = IMEM_AWIDTH,
    parameter int RWIDTH = IMEM_RWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic              in_valid,
    input  logic [RWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [RWIDTH-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_full,
    output logic [AWIDTH:0]   word_count
);

    ldr_state_t        state;
    ldr_state_t        state_nxt;
    logic [AWIDTH-1:0] addr_ptr;
    logic              at_top;
    logic              start_ok;
    logic              beat;
    logic              finish;

    assign start_ok = start && (state != LDR_LOAD);
    assign beat     = in_valid && in_ready;
    assign finish   = beat && (in_last || at_top);

    // Counter is frozen at the top word so the pointer never wraps.
    ldr_addr_ctr #(
        .W(AWIDTH)
    ) u_ctr (
        .clk (clk),
        .rst (rst),
        .load(start_ok),
        .d   (start_addr),
        .en  (beat && !at_top),
        .q   (addr_ptr),
        .tc  (at_top)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LDR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == LDR_LOAD);
        unique case (state)
            LDR_IDLE: if (start) state_nxt = LDR_LOAD;
            LDR_LOAD: if (finish) state_nxt = LDR_DONE;
            LDR_DONE: if (start) state_nxt = LDR_LOAD;
            default:  state_nxt = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err_full   <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= beat;
            if (beat) begin
                mem_addr   <= addr_ptr;
                mem_wdata  <= in_data;
                word_count <= word_count + (AWIDTH+1)'(1);
            end
            if (start_ok) begin
                word_count <= '0;
                done       <= 1'b0;
                err_full   <= 1'b0;
                cpu_hold   <= 1'b1;
            end
            if (finish) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                err_full <= !in_last;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued
// as words are offered and matched against mem_we cycles.
module tb_instr_mem_loader;

    localparam int AW = 6;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err_full;
    logic [AW:0]   word_count;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_load;
    logic [AW-1:0] m_ptr;

    instr_mem_loader #(
        .AWIDTH(AW),
        .RWIDTH(RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err_full  (err_full),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Each mem_we cycle must match the oldest queued write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h required=none",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got=%0d/%h required=%0d/%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] a);
        start      = 1'b1;
        start_addr = a;
        step();
        start  = 1'b0;
        m_load = 1'b1;
        m_ptr  = a;
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 0) begin
            errors++;
            $display("FAIL start hold=%b done=%b cnt=%0d required=1/0/0",
                     cpu_hold, done, word_count);
        end
    endtask

    task automatic send(input logic [RW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        checks++;
        if (in_ready !== m_load) begin
            errors++;
            $display("FAIL in_ready got=%b required=%b", in_ready, m_load);
        end
        if (m_load) begin
            sb.push_back('{addr: m_ptr, data: d});
            if (last || m_ptr == AW'(2**AW - 1)) m_load = 1'b0;
            else m_ptr = m_ptr + 1'b1;
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_end(input logic e_done, input logic e_err,
                             input int e_cnt, input logic e_hold);
        checks++;
        if (done !== e_done || err_full !== e_err ||
            word_count !== (AW+1)'(e_cnt) || cpu_hold !== e_hold) begin
            errors++;
            $display("FAIL end done=%b err=%b cnt=%0d hold=%b required=%b/%b/%0d/%b",
                     done, err_full, word_count, cpu_hold,
                     e_done, e_err, e_cnt, e_hold);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err_full,
             word_count, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got_nonzero we=%b hold=%b done=%b required=0",
                     mem_we, cpu_hold, done);
        end
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL idle rdy=%b we=%b required=0/0", in_ready, mem_we);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clean_load();
        do_start(0);
        check_end(0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) send(32'h11111111 * i, i == 4);
        check_end(1, 0, 4, 0);
        drain();
    endtask

    task automatic test_gapped();
        do_start(10);
        send(32'hA0A0A0A0, 1'b0);
        step();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== AW'(10)) begin
            errors++;
            $display("FAIL gap we=%b addr=%0d required=0/10", mem_we, mem_addr);
        end
        send(32'hB0B0B0B0, 1'b1);
        check_end(1, 0, 2, 0);
        drain();
    endtask

    task automatic test_overflow();
        do_start(62);
        send(32'h00000062, 1'b0);
        send(32'h00000063, 1'b0);
        check_end(1, 1, 2, 0);
        send(32'h00000064, 1'b0);
        check_end(1, 1, 2, 0);
        drain();
    endtask

    task automatic test_top_last();
        do_start(63);
        send(32'hC0FFEE63, 1'b1);
        check_end(1, 0, 1, 0);
        drain();
    endtask

    task automatic test_start_ignored();
        do_start(20);
        send(32'h20202020, 1'b0);
        start      = 1'b1;
        start_addr = 40;
        send(32'h21212121, 1'b0);
        start = 1'b0;
        send(32'h22222222, 1'b1);
        check_end(1, 0, 3, 0);
        drain();
    endtask

    task automatic test_reset_mid_load();
        do_start(0);
        send(32'h0000AAA0, 1'b0);
        send(32'h0000AAA1, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'h0000AAA2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, cpu_hold, done, err_full, word_count, in_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset we=%b hold=%b done=%b cnt=%0d required=0",
                     mem_we, cpu_hold, done, word_count);
        end
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        m_load = 1'b0;
        do_start(0);
        send(32'h5A5A0000, 1'b0);
        send(32'h5A5A0001, 1'b1);
        check_end(1, 0, 2, 0);
        drain();
    endtask

    task automatic test_rearm();
        do_start(5);
        check_end(0, 0, 0, 1);
        send(32'h55555555, 1'b1);
        check_end(1, 0, 1, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        do_start(30);
        for (int i = 0; i < 8; i++) send($urandom, i == 7);
        check_end(1, 0, 8, 0);
        drain();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        m_load     = 1'b0;
        m_ptr      = '0;
        test_reset();
        test_clean_load();
        test_gapped();
        test_overflow();
        test_top_last();
        test_start_ignored();
        test_reset_mid_load();
        test_rearm();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
